// File: rtl/ex_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_unit
//  Desc     : Iterative RV32M multiply/divide unit for the EX stage.
//             Shift-add multiply and restoring radix-2 divide, one bit per
//             cycle, with one-cycle resolution of divide special cases.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [4:0]            rd_in,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            rd_out
);

    localparam int COUNT_W = $clog2(DATA_WIDTH);
    localparam int W       = DATA_WIDTH;

    localparam logic [COUNT_W-1:0] c_last_count = COUNT_W'(DATA_WIDTH - 1);
    localparam logic [W-1:0]       c_min_neg    = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_DIVU   = 3'b101;
    localparam logic [2:0] c_F3_REM    = 3'b110;
    localparam logic [2:0] c_F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [COUNT_W-1:0]   r_count;
    logic [2:0]           r_funct3;
    logic [4:0]           r_rd;
    logic [W-1:0]         r_a;       // multiplicand / dividend magnitude
    logic [W-1:0]         r_b;       // multiplier / divisor magnitude
    logic [2*W-1:0]       r_acc;     // product, or {remainder, quotient}
    logic                 r_neg;     // final result must be negated
    logic                 r_done;
    logic [W-1:0]         r_result;
    logic [4:0]           r_rd_out;

    // Operand decode at issue time
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [W-1:0]         w_a_mag;
    logic [W-1:0]         w_b_mag;
    logic                 w_res_neg;
    logic                 w_div_zero;
    logic                 w_ovf;
    logic [W-1:0]         w_special_res;

    // Per-iteration datapath
    logic [W:0]           w_mul_sum;
    logic [2*W-1:0]       w_mul_next;
    logic [W:0]           w_rem_shift;
    logic                 w_ge;
    logic [W-1:0]         w_rem_diff;
    logic [W-1:0]         w_rem_new;
    logic [2*W-1:0]       w_div_next;
    logic [2*W-1:0]       w_acc_next;
    logic [2*W-1:0]       w_prod_signed;
    logic [W-1:0]         w_final;

    // Classify the incoming operands: which are signed, their magnitudes,
    // the sign of the eventual result and the one-cycle special cases.
    always_comb begin
        w_a_neg = op_a[W-1] & ((funct3 == c_F3_MULH) | (funct3 == c_F3_MULHSU) |
                               (funct3 == c_F3_DIV)  | (funct3 == c_F3_REM));
        w_b_neg = op_b[W-1] & ((funct3 == c_F3_MULH) | (funct3 == c_F3_DIV) |
                               (funct3 == c_F3_REM));
        w_a_mag = w_a_neg ? -op_a : op_a;
        w_b_mag = w_b_neg ? -op_b : op_b;
        // Remainder follows the dividend; everything else follows the XOR.
        w_res_neg  = (funct3 == c_F3_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = funct3[2] & (op_b == '0);
        w_ovf      = ((funct3 == c_F3_DIV) | (funct3 == c_F3_REM)) &
                     (op_a == c_min_neg) & (op_b == '1);
        if (w_div_zero) begin
            w_special_res = funct3[1] ? op_a : '1;
        end else begin
            w_special_res = funct3[1] ? '0 : c_min_neg;
        end
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        // Multiply: add the multiplicand into the high half when the current
        // multiplier bit is set, then shift the whole product right.
        w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_b[0] ? r_a : '0)};
        w_mul_next = {w_mul_sum, r_acc[W-1:1]};
        // Divide: bring down the next dividend bit and try subtracting.
        w_rem_shift = {r_acc[2*W-1:W], r_a[W-1]};
        w_ge        = (w_rem_shift >= {1'b0, r_b});
        w_rem_diff  = w_rem_shift[W-1:0] - r_b;
        w_rem_new   = w_ge ? w_rem_diff : w_rem_shift[W-1:0];
        w_div_next  = {w_rem_new, r_acc[W-2:0], w_ge};
        w_acc_next  = r_funct3[2] ? w_div_next : w_mul_next;
    end

    // Apply the sign correction and select the half/part the op returns.
    always_comb begin
        w_prod_signed = r_neg ? -w_acc_next : w_acc_next;
        w_final       = '0;
        case (r_funct3)
            c_F3_MUL:                           w_final = w_prod_signed[W-1:0];
            c_F3_MULH, c_F3_MULHSU, c_F3_MULHU: w_final = w_prod_signed[2*W-1:W];
            c_F3_DIV, c_F3_DIVU:
                w_final = r_neg ? -w_acc_next[W-1:0] : w_acc_next[W-1:0];
            c_F3_REM, c_F3_REMU:
                w_final = r_neg ? -w_acc_next[2*W-1:W] : w_acc_next[2*W-1:W];
            default:                            w_final = '0;
        endcase
    end

    // Control FSM plus operand, accumulator and registered output updates.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_funct3 <= funct3;
                        r_rd     <= rd_in;
                        r_a      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_neg    <= w_res_neg;
                        r_acc    <= '0;
                        r_count  <= '0;
                        if (w_div_zero || w_ovf) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_special_res;
                            r_rd_out <= rd_in;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    if (r_funct3[2]) begin
                        r_a <= r_a << 1;
                    end else begin
                        r_b <= r_b >> 1;
                    end
                    if (r_count == c_last_count) begin
                        r_state  <= ST_DONE;
                        r_count  <= '0;
                        r_done   <= 1'b1;
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                    end else begin
                        r_count <= r_count + COUNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Hold upstream while accepting an op or iterating; release in DONE.
    always_comb begin
        stall_req = ((r_state == ST_IDLE) && start && !flush) || (r_state == ST_CALC);
    end

    assign busy   = (r_state == ST_CALC);
    assign done   = r_done;
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv_unit
//  Desc     : Self-checking bench for ex_muldiv_unit: directed RV32M cases,
//             special cases, flush, reset and back-to-back issue, plus random
//             operations checked against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour in plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f[2] && b == 0) return 1'b1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Called at a negedge; returns the number of edges until done shows.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp);
        int n;
        int exp_lat;
        exp_lat = is_special(f, a, b) ? 0 : 32;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        #1 check({tag, "_stall_start"}, 32'(stall_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_result"}, result, exp);
        check({tag, "_rd"}, 32'(rd_out), 32'(rd));
        check({tag, "_stall_done"}, 32'(stall_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        int          n;
        bit          saw;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rr;

        rstn = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        rstn = 1'b1;

        // Reset in the middle of a multiply
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw |= done;
        end
        check("midrst_no_done", 32'(saw), 32'd0);

        // Directed multiply and divide
        run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
        run_op("mulh",   3'd1, 32'd7, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFF);
        run_op("mulhu",  3'd3, 32'd7, 32'hFFFF_FFFD, 5'd4, 32'h0000_0006);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run_op("divu",   3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF);

        // Special cases
        run_op("div0",   3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
        run_op("remu0",  3'd7, 32'd5, 32'd0, 5'd11, 32'd5);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);

        // Flush partway through a DIVU, then a fresh MUL
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd7; rd_in = 5'd14; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_stall", 32'(stall_req), 32'd0);
        run_op("post_flush_mul", 3'd0, 32'd3, 32'd4, 5'd15, 32'd12);

        // Back-to-back with start held high across DONE
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd21;
        wait_done(n);
        check("b2b1_latency", 32'(n), 32'd32);
        check("b2b1_result", result, 32'd30);
        check("b2b1_rd", 32'(rd_out), 32'd9);
        check("b2b1_stall_done", 32'(stall_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle_done", 32'(done), 32'd0);
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_stall", 32'(stall_req), 32'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b2_busy", 32'(busy), 32'd1);
        wait_done(n);
        check("b2b2_latency", 32'(n), 32'd32);
        check("b2b2_result", result, 32'd14);
        check("b2b2_rd", 32'(rd_out), 32'd21);

        // Random operations against the reference model
        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            rr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, rr, model(rf, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
